// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin arbiter sharing one SPI byte engine
// between two requesters, with chip-select setup/hold framing.
module spi_bus_scheduler #(
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] req_len0,
  input  logic [3:0] req_len1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_pop,
  output logic [7:0] rx_data,
  output logic [1:0] rx_valid,
  output logic [1:0] done,
  output logic [1:0] grant,
  output logic [1:0] cs_n,
  output logic [7:0] m_tx_data,
  output logic       m_start,
  input  logic [7:0] m_rx_data,
  input  logic       m_done
);

  localparam int CMAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                        CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, START, WAIT, CAPTURE, HOLD, FINISH
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q;
  logic          last_q;
  logic [3:0]    rem_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    rx_data_q;
  logic [1:0]    rx_valid_q;
  logic [7:0]    m_tx_data_q;
  logic          pick;
  logic [1:0]    own_oh;

  // On a tie the requester that did not go last wins
  assign pick   = (req == 2'b11) ? ~last_q : req[1];
  assign own_oh = owner_q ? 2'b10 : 2'b01;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_LAST) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (m_done) state_d = CAPTURE;
      CAPTURE: state_d = (rem_q != 4'd0) ? START : HOLD;
      HOLD:    if (cnt_q == HOLD_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner, byte counter, timers and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rem_q       <= 4'd0;
      cnt_q       <= '0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 2'b00;
      m_tx_data_q <= 8'd0;
    end else begin
      rx_valid_q <= (state_q == CAPTURE) ? own_oh : 2'b00;
      if (state_d == START)
        m_tx_data_q <= owner_q ? tx_data1 : tx_data0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= pick;
            rem_q   <= pick ? req_len1 : req_len0;
            cnt_q   <= '0;
          end
        end
        SETUP, HOLD: cnt_q <= cnt_q + 1'b1;
        CAPTURE: begin
          rx_data_q <= m_rx_data;
          cnt_q     <= '0;
          if (rem_q != 4'd0) rem_q <= rem_q - 4'd1;
        end
        FINISH: last_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state and owner
  always_comb begin
    cs_n    = 2'b11;
    grant   = 2'b00;
    tx_pop  = 2'b00;
    done    = 2'b00;
    m_start = 1'b0;
    if (state_q != IDLE) grant = own_oh;
    case (state_q)
      SETUP, START, WAIT, CAPTURE, HOLD: cs_n = ~own_oh;
      default: ;
    endcase
    if (state_q == START) begin
      m_start = 1'b1;
      tx_pop  = own_oh;
    end
    if (state_q == FINISH) done = own_oh;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign m_tx_data = m_tx_data_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: randomized scoreboard bench with a
// behavioural 8-cycle SPI byte engine and requester models.
module tb_spi_bus_scheduler;

  localparam int S  = 2;
  localparam int H  = 2;
  localparam int BT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] req_len0 = 4'd0;
  logic [3:0] req_len1 = 4'd0;
  logic [7:0] tx_data0 = 8'd0;
  logic [7:0] tx_data1 = 8'd0;
  logic [1:0] tx_pop;
  logic [7:0] rx_data;
  logic [1:0] rx_valid;
  logic [1:0] done;
  logic [1:0] grant;
  logic [1:0] cs_n;
  logic [7:0] m_tx_data;
  logic       m_start;
  logic [7:0] m_rx_data = 8'd0;
  logic       m_done = 1'b0;

  spi_bus_scheduler #(
    .CS_SETUP_CYCLES(S),
    .CS_HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_len0(req_len0), .req_len1(req_len1),
    .tx_data0(tx_data0), .tx_data1(tx_data1),
    .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid),
    .done(done), .grant(grant), .cs_n(cs_n),
    .m_tx_data(m_tx_data), .m_start(m_start),
    .m_rx_data(m_rx_data), .m_done(m_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       own;
    logic [7:0] tx;
    logic [7:0] rx;
  } byte_t;

  byte_t      exp_byte[$];
  byte_t      pend_rx[$];
  logic       exp_done[$];
  int         exp_low0[$];
  int         exp_low1[$];
  logic [7:0] resp_q[$];
  logic [3:0] lens0[$], lens1[$];
  logic [7:0] bytes0[$], bytes1[$];
  logic [3:0] plen0[$], plen1[$];
  logic [7:0] ptx0[$], ptx1[$], prx0[$], prx1[$];

  int   checks = 0;
  int   errors = 0;
  int   st_cnt = 0;
  int   low0 = 0;
  int   low1 = 0;
  bit   drop0 = 1'b0;
  logic m_last = 1'b1;
  byte_t me;
  logic  md;

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester models: present bytes, pop on tx_pop, retire on done
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_pop[0] && bytes0.size() > 0) void'(bytes0.pop_front());
      if (tx_pop[1] && bytes1.size() > 0) void'(bytes1.pop_front());
      if (done[0] && lens0.size() > 0) void'(lens0.pop_front());
      if (done[1] && lens1.size() > 0) void'(lens1.pop_front());
    end
    req[0] = (lens0.size() > 0) && !drop0;
    req[1] = (lens1.size() > 0);
    if (grant[0]) req_len0 = 4'($urandom);
    else req_len0 = (lens0.size() > 0) ? lens0[0] : 4'd0;
    if (grant[1]) req_len1 = 4'($urandom);
    else req_len1 = (lens1.size() > 0) ? lens1[0] : 4'd0;
    tx_data0 = (bytes0.size() > 0) ? bytes0[0] : 8'($urandom);
    tx_data1 = (bytes1.size() > 0) ? bytes1[0] : 8'($urandom);
  end

  // Engine model: 8-cycle byte, rx byte loaded after the done cycle
  int         eng_cnt = 0;
  bit         eng_fin = 1'b0;
  bit         eng_quiet = 1'b0;
  logic [7:0] eng_tx = 8'd0;
  logic [7:0] eng_rx = 8'd0;
  always @(negedge clk) begin
    if (rst) eng_quiet = 1'b1;
    if (eng_fin) begin
      m_done    = 1'b0;
      m_rx_data = eng_rx;
      eng_fin   = 1'b0;
    end
    if (m_start && !rst) begin
      eng_cnt   = BT;
      eng_tx    = m_tx_data;
      eng_quiet = 1'b0;
      eng_rx    = 8'h00;
      if (resp_q.size() > 0) eng_rx = resp_q.pop_front();
    end else if (eng_cnt > 0) begin
      if (!eng_quiet)
        chk(m_tx_data == eng_tx, "m_tx_data_stable", m_tx_data, eng_tx);
      eng_cnt--;
      if (eng_cnt == 0) begin
        m_done  = 1'b1;
        eng_fin = 1'b1;
      end
    end
  end

  // Monitor: pop expected events whenever the DUT presents them
  always @(negedge clk) begin
    if (rst) begin
      low0 = 0;
      low1 = 0;
    end else begin
      if (m_start) begin
        st_cnt++;
        if (exp_byte.size() == 0) begin
          chk(1'b0, "extra_m_start", m_tx_data, 0);
        end else begin
          me = exp_byte.pop_front();
          chk(m_tx_data == me.tx, "m_tx_data", m_tx_data, me.tx);
          chk(tx_pop == oh(me.own), "tx_pop", tx_pop, oh(me.own));
          chk(grant == oh(me.own), "grant", grant, oh(me.own));
          pend_rx.push_back(me);
        end
      end else begin
        chk(tx_pop == 2'b00, "tx_pop_idle", tx_pop, 0);
      end
      if (rx_valid != 2'b00) begin
        if (pend_rx.size() == 0) begin
          chk(1'b0, "extra_rx_valid", rx_valid, 0);
        end else begin
          me = pend_rx.pop_front();
          chk(rx_data == me.rx, "rx_data", rx_data, me.rx);
          chk(rx_valid == oh(me.own), "rx_valid", rx_valid, oh(me.own));
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) begin
          chk(1'b0, "extra_done", done, 0);
        end else begin
          md = exp_done.pop_front();
          chk(done == oh(md), "done", done, oh(md));
          chk(cs_n == 2'b11, "cs_n_at_done", cs_n, 2'b11);
        end
      end
      chk(cs_n != 2'b00, "cs_n_overlap", cs_n, 2'b11);
      if (!cs_n[0]) low0++;
      else if (low0 > 0) begin
        if (exp_low0.size() == 0) chk(1'b0, "cs0_extra", low0, 0);
        else chk(low0 == exp_low0[0], "cs0_low_cycles", low0, exp_low0[0]);
        if (exp_low0.size() > 0) void'(exp_low0.pop_front());
        low0 = 0;
      end
      if (!cs_n[1]) low1++;
      else if (low1 > 0) begin
        if (exp_low1.size() == 0) chk(1'b0, "cs1_extra", low1, 0);
        else chk(low1 == exp_low1[0], "cs1_low_cycles", low1, exp_low1[0]);
        if (exp_low1.size() > 0) void'(exp_low1.pop_front());
        low1 = 0;
      end
    end
  end

  // Queue a transaction for planning; mode 1 = A5/3C, 2 = counting
  task automatic add_txn(input logic o, input int len, input int mode);
    logic [7:0] t, r;
    if (o) plen1.push_back(4'(len));
    else   plen0.push_back(4'(len));
    for (int k = 0; k <= len; k++) begin
      t = (mode == 1) ? 8'hA5 : (mode == 2) ? 8'(k + 1) : 8'($urandom);
      r = (mode == 1) ? 8'h3C : 8'($urandom);
      if (o) begin ptx1.push_back(t); prx1.push_back(r); end
      else   begin ptx0.push_back(t); prx0.push_back(r); end
    end
  endtask

  // Reference model: round-robin order over all pending transactions
  task automatic schedule();
    logic       o;
    logic [3:0] l;
    logic [7:0] t, r;
    int         n;
    while (plen0.size() > 0 || plen1.size() > 0) begin
      if (plen0.size() > 0 && plen1.size() > 0) o = ~m_last;
      else o = (plen1.size() > 0);
      if (o) begin
        l = plen1.pop_front();
        lens1.push_back(l);
      end else begin
        l = plen0.pop_front();
        lens0.push_back(l);
      end
      n = int'(l) + 1;
      for (int k = 0; k < n; k++) begin
        if (o) begin
          t = ptx1.pop_front(); r = prx1.pop_front();
          bytes1.push_back(t);
        end else begin
          t = ptx0.pop_front(); r = prx0.pop_front();
          bytes0.push_back(t);
        end
        exp_byte.push_back(byte_t'({o, t, r}));
        resp_q.push_back(r);
      end
      if (o) exp_low1.push_back(S + 1 + n * (BT + 2) + H);
      else   exp_low0.push_back(S + 1 + n * (BT + 2) + H);
      exp_done.push_back(o);
      m_last = o;
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    int left;
    left = exp_byte.size() + pend_rx.size() + exp_done.size()
         + lens0.size() + lens1.size();
    while (left > 0 && c < budget) begin
      @(posedge clk);
      c++;
      left = exp_byte.size() + pend_rx.size() + exp_done.size()
           + lens0.size() + lens1.size();
    end
    chk(left == 0, "drain_timeout", left, 0);
    repeat (3) @(posedge clk);
    #2;
    chk(exp_low0.size() + exp_low1.size() == 0, "cs_low_pending",
        exp_low0.size() + exp_low1.size(), 0);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c = 0;
    while (st_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(st_cnt >= target, "start_timeout", st_cnt, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(cs_n == 2'b11, {tag, "_cs_n"}, cs_n, 2'b11);
    chk(grant == 2'b00, {tag, "_grant"}, grant, 0);
    chk(m_start == 1'b0, {tag, "_m_start"}, m_start, 0);
    chk(done == 2'b00, {tag, "_done"}, done, 0);
    chk(tx_pop == 2'b00, {tag, "_tx_pop"}, tx_pop, 0);
  endtask

  int base;
  int n0, n1;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    chk(rx_valid == 2'b00, "reset_rx_valid", rx_valid, 0);
    chk(rx_data == 8'd0, "reset_rx_data", rx_data, 0);
    chk(m_tx_data == 8'd0, "reset_m_tx_data", m_tx_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Tie from reset: order 0,1,0,1
    add_txn(1'b0, 1, 0);
    add_txn(1'b1, 0, 0);
    add_txn(1'b0, 2, 0);
    add_txn(1'b1, 1, 0);
    schedule();
    drain(2000);

    // Single byte A5 out, 3C back
    add_txn(1'b0, 0, 1);
    schedule();
    drain(500);

    // Four-byte burst on requester 1
    add_txn(1'b1, 3, 2);
    schedule();
    drain(1000);

    // Request withdrawn during the second byte
    base = st_cnt;
    add_txn(1'b0, 2, 0);
    schedule();
    wait_starts(base + 2, 200);
    drop0 = 1'b1;
    drain(1000);
    drop0 = 1'b0;

    // Maximum length: 16 bytes
    add_txn(1'b0, 15, 0);
    schedule();
    drain(2000);

    // Reset while the engine is mid-byte
    base = st_cnt;
    add_txn(1'b0, 1, 0);
    schedule();
    wait_starts(base + 1, 200);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_byte.delete(); pend_rx.delete(); exp_done.delete();
    exp_low0.delete(); exp_low1.delete(); resp_q.delete();
    lens0.delete(); bytes0.delete();
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    add_txn(1'b1, 0, 0);
    add_txn(1'b0, 1, 0);
    schedule();
    drain(1000);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++) add_txn(1'b0, $urandom_range(0, 5), 0);
      for (int k = 0; k < n1; k++) add_txn(1'b1, $urandom_range(0, 5), 0);
      schedule();
      drain(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
